// File: rtl/inv_key_expansion_iter.sv
// Iterative AES-128 inverse key schedule: walks round keys NR..0
// backwards from the last-round key over a valid/ready stream.
module inv_key_expansion_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [3:0] NR_R = 4'(NR);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] key_reg;
  logic [127:0] key_nxt;
  logic [3:0]   round;
  logic [3:0]   round_nxt;
  logic         done_nxt;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_in;
  logic [31:0]  sb;
  logic [3:0]   rc_idx;
  logic [7:0]   rc;

  assign a0 = key_reg[127:96];
  assign a1 = key_reg[95:64];
  assign a2 = key_reg[63:32];
  assign a3 = key_reg[31:0];

  assign w3 = a3 ^ a2;
  assign w2 = a2 ^ a1;
  assign w1 = a1 ^ a0;

  assign sb_in = {w3[23:0], w3[31:24]};

  sub_byte u_sub_byte (
    .a  (sb_in),
    .sb (sb)
  );

  // The step back from round r uses the rcon of the key that produced it.
  assign rc_idx = round - 4'd1;

  always_comb begin
    rc = 8'h00;
    case (rc_idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign w0 = a0 ^ sb ^ {rc, 24'h000000};

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    round_nxt = round;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          round_nxt = NR_R;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round == 4'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            key_nxt   = {w0, w1, w2, w3};
            round_nxt = round - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      round   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      round   <= round_nxt;
      done    <= done_nxt;
    end
  end

  assign busy     = (state == EMIT);
  assign rk_valid = (state == EMIT);
  assign rk_out   = key_reg;
  assign rk_round = round;

endmodule

// AES forward S-box on four bytes, built from the GF(2^8)
// inverse (x^254) followed by the affine transform.
module sub_byte (
  input  logic [31:0] a,
  output logic [31:0] sb
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  always_comb begin
    sb = '0;
    for (int i = 0; i < 4; i++) begin
      sb[i*8 +: 8] = sbox(a[i*8 +: 8]);
    end
  end

endmodule
